image_frame_tx: RTL and testbench
=================================

# image_frame_tx

Transmit side of the host image-load link. Accepts one full `DEPTH`-bit frame in parallel and serialises it into the 32-bit command-word stream `{send_img, addr[14:0], din[15:0]}` that the image-load receiver consumes. Each data word writes one 16-bit chunk at bit offset `addr`. A final commit word with `send_img` set makes the receiver publish its buffer. The block sits between the solver's frame output and the host/display link.

## Interface
Parameters:
- `DEPTH`, default `` `DEPTH `` (from `def.vh`): frame width in bits. Must be a multiple of 16 and ≤ 32768.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `frame_in`  in  DEPTH  frame to send; sampled only on an accepted handshake.
- `frame_valid`  in  1  a frame is offered.
- `frame_ready`  out  1  high only in IDLE.
- `word_out`  out  32  `{send_img, addr, din}` command word.
- `word_valid`  out  1  `word_out` is valid.
- `word_ready`  in  1  downstream accepts the word.
- `busy`  out  1  high in SEND or COMMIT.
- `done`  out  1  one-cycle pulse after the commit word transfers.

## Operation
- N = DEPTH/16 chunks. Chunk k = `frame_in[16k +: 16]`, sent with `addr` = 16k, which is a bit offset, not a chunk index.
- States:
  - IDLE: `frame_ready`=1. On `frame_valid`, latch the frame into an internal register, set k=0, and go to SEND.
  - SEND: present chunk k with `send_img`=0. On transfer: if k=N-1, go to COMMIT; otherwise k++.
  - COMMIT: present `{1'b1, 16(N-1), chunk N-1}`. On transfer, go to IDLE and pulse `done`.
- The commit word repeats the last chunk on purpose. The receiver publishes its buffer before that cycle's write lands, so the last chunk must already be written by the preceding data word; the rewrite is harmless.
- Transfer = `word_valid && word_ready`. While `word_valid` is high and `word_ready` is low, `word_out` and `word_valid` are held stable.
- `frame_in` changes after acceptance have no effect.
- k is `$clog2(N)` bits. `addr` = `{k, 4'b0}`, zero-extended to 15 bits.

## Timing
- Reset values: `word_out`=0, `word_valid`=0, `busy`=0, `done`=0, `frame_ready`=1 (state IDLE). The latched frame register is cleared.
- Accept at cycle t. Chunk 0 is valid at t+1.
- With `word_ready` held high, one word transfers per cycle. Total: N+1 words, with the commit at t+N+1.
- `done` is high in the cycle after the commit transfer. `frame_ready` is 1 in that same cycle, so a back-to-back frame can be accepted there.
- `frame_valid` outside IDLE is ignored. There is no queueing.
- Reset asserted mid-frame: the block returns to IDLE immediately and drops `word_valid`. The partial frame is abandoned, and the receiver must be reset alongside.

## Configuration
- `IMAGE_TX_DELTA_EN` defined:
  - A shadow copy of the last committed frame is kept.
  - In SEND, a chunk equal to its shadow is skipped. `word_valid` stays 0 for that cycle and k advances, costing one cycle per skipped chunk.
  - The first frame after reset always sends all chunks.
  - The shadow is updated on the commit transfer.
  - COMMIT is always sent, even when no chunk changed.
- Undefined: every chunk of every frame is sent. No shadow register exists.

## Structure
- Shared package/header (`def.vh`) holds:
  - `DEPTH` and `CHUNK_W`=16.
  - Field positions `SEND_BIT`=31, `ADDR_MSB`=30, `ADDR_LSB`=16, `DIN_MSB`=15.
  - State encoding: IDLE/SEND/COMMIT.
- One natural sub-module: `image_delta_cmp`, which compares chunk k of the current and shadow frames. It is instantiated only under `IMAGE_TX_DELTA_EN`.

## Test plan
Bench uses DEPTH=64 (N=4).
- Reset then idle: `frame_ready`=1, `word_valid`=0, `busy`=0, `done`=0.
- Frame `0x4444_3333_2222_1111`, `word_ready`=1 → words `0x0000_1111`, `0x0010_2222`, `0x0020_3333`, `0x0030_4444`, `0x8030_4444`. `done` follows one cycle later.
- Same frame with `word_ready` toggling 1/0 → identical word sequence, and `word_out` stable during every stall.
- Reset pulsed after the second word → IDLE next cycle, `word_valid`=0. A fresh frame then restarts at addr 0.
- Under `IMAGE_TX_DELTA_EN`: first frame as above, then `0x4444_3333_AAAA_1111` → only `0x0010_AAAA` and the commit `0x8030_4444`.
- Back-to-back: `frame_valid` held high → second frame accepted in the `done` cycle, and its chunk 0 appears on the next cycle.

Source files
------------

// File: rtl/image_frame_tx_pkg.sv
//------------------------------------------------------------------------------
// Module   : image_frame_tx_pkg
// Purpose  : Shared constants, command-word field positions and FSM state
//            encoding for the image-load transmit path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package image_frame_tx_pkg;

  // Default frame width in bits (multiple of 16, at most 32768)
  localparam int DEPTH    = 64;
  localparam int CHUNK_W  = 16;

  // Command word layout {send_img, addr[14:0], din[15:0]}
  localparam int SEND_BIT = 31;
  localparam int ADDR_MSB = 30;
  localparam int ADDR_LSB = 16;
  localparam int DIN_MSB  = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    COMMIT = 2'd2
  } tx_state_t;

  // Chunk index width; kept at least one bit for single-chunk frames
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/image_delta_cmp.sv
//------------------------------------------------------------------------------
// Module   : image_delta_cmp
// Purpose  : Compares chunk idx of the current frame against the same chunk
//            of the shadow (last committed) frame.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module image_delta_cmp
  import image_frame_tx_pkg::*;
#(
  parameter int FRAME_W = 64,
  parameter int KW      = 2
) (
  input  logic [FRAME_W-1:0] cur,
  input  logic [FRAME_W-1:0] shadow,
  input  logic [KW-1:0]      idx,
  output logic               equal
);

  // Pure combinational chunk compare
  always_comb begin
    equal = (cur[idx*CHUNK_W +: CHUNK_W] == shadow[idx*CHUNK_W +: CHUNK_W]);
  end

endmodule

`default_nettype wire

// File: rtl/image_frame_tx.sv
//------------------------------------------------------------------------------
// Module   : image_frame_tx
// Purpose  : Serialises a parallel DEPTH-bit frame into 32-bit image-load
//            command words {send_img, addr, din}, followed by a commit word.
// Options  : IMAGE_TX_DELTA_EN - skip chunks unchanged since the last
//            committed frame (shadow copy kept internally).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module image_frame_tx #(
  parameter int DEPTH = image_frame_tx_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] frame_in,
  input  logic             frame_valid,
  output logic             frame_ready,
  output logic [31:0]      word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             done
);

  import image_frame_tx_pkg::*;

  localparam int N  = DEPTH / CHUNK_W;
  localparam int KW = idx_w(N);

  tx_state_t            state, state_nx;
  logic [DEPTH-1:0]     frame_q;
  logic [KW-1:0]        k;
  logic [CHUNK_W-1:0]   chunk;
  logic [ADDR_MSB-ADDR_LSB:0] addr;
  logic                 last;
  logic                 skip;
  logic                 advance;

  assign chunk   = frame_q[k*CHUNK_W +: CHUNK_W];
  // addr is a bit offset: chunk index times 16
  assign addr    = (ADDR_MSB-ADDR_LSB+1)'({k, 4'b0000});
  assign last    = (k == KW'(N-1));
  // A skipped chunk consumes its cycle exactly like a transferred one
  assign advance = skip || word_ready;

`ifdef IMAGE_TX_DELTA_EN
  logic [DEPTH-1:0] shadow_q;
  logic             shadow_ok;
  logic             chunk_eq;

  image_delta_cmp #(
    .FRAME_W (DEPTH),
    .KW      (KW)
  ) u_delta_cmp (
    .cur    (frame_q),
    .shadow (shadow_q),
    .idx    (k),
    .equal  (chunk_eq)
  );

  assign skip = (state == SEND) && shadow_ok && chunk_eq;

  // Shadow tracks the last frame whose commit word actually transferred
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      shadow_ok <= 1'b0;
    end else if (state == COMMIT && word_ready) begin
      shadow_q  <= frame_q;
      shadow_ok <= 1'b1;
    end
  end
`else
  assign skip = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and command-word generation
  always_comb begin
    state_nx   = state;
    word_valid = 1'b0;
    word_out   = '0;
    case (state)
      IDLE: begin
        if (frame_valid) state_nx = SEND;
      end
      SEND: begin
        word_valid = !skip;
        word_out   = {1'b0, addr, chunk};
        if (advance && last) state_nx = COMMIT;
      end
      COMMIT: begin
        // Last chunk is repeated so it is already written when published
        word_valid = 1'b1;
        word_out   = {1'b1, addr, chunk};
        if (word_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frame latch, chunk index and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      k       <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == COMMIT) && word_ready;
      if (state == IDLE && frame_valid) begin
        frame_q <= frame_in;
        k       <= '0;
      end else if (state == SEND && advance && !last) begin
        k <= k + 1'b1;
      end
    end
  end

  assign frame_ready = (state == IDLE);
  assign busy        = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_image_frame_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_image_frame_tx
// Purpose  : Self-checking bench for image_frame_tx (DEPTH=64, four chunks)
//            with a queue-based reference model of the command-word stream.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_image_frame_tx;

  localparam int DEPTH = 64;
  localparam int NCH   = DEPTH / 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DEPTH-1:0] frame_in = '0;
  logic             frame_valid = 1'b0;
  logic             frame_ready;
  logic [31:0]      word_out;
  logic             word_valid;
  logic             word_ready = 1'b0;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: last committed frame
  logic [DEPTH-1:0] model_shadow = '0;
  bit               model_shadow_ok = 1'b0;
  bit               delta_en;

  image_frame_tx #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected word stream for one frame from the link rules
  task automatic build_expect(input logic [DEPTH-1:0] f, output logic [31:0] q[$]);
    logic [15:0] c, s;
    q = {};
    for (int i = 0; i < NCH; i++) begin
      c = f[16*i +: 16];
      s = model_shadow[16*i +: 16];
      if (!(delta_en && model_shadow_ok && c == s))
        q.push_back({1'b0, 15'(16*i), c});
    end
    q.push_back({1'b1, 15'(16*(NCH-1)), f[16*(NCH-1) +: 16]});
  endtask

  // mode: 0 ready high, 1 toggling, 2 random
  task automatic run_frame(input logic [DEPTH-1:0] f, input int mode, input bit already,
                           input bit btb, input logic [DEPTH-1:0] f2, input int abort_after);
    logic [31:0] q[$];
    logic [31:0] exp, held;
    bit stalled, commit_seen;
    int cyc, pops;
    build_expect(f, q);
    if (!already) begin
      @(negedge clk);
      frame_in = f;
      frame_valid = 1'b1;
      check("accept_ready", frame_ready, 1);
    end
    @(posedge clk);
    #1;
    frame_valid = btb;
    frame_in = btb ? f2 : {$urandom, $urandom};
    stalled = 0; commit_seen = 0; cyc = 0; pops = 0;
    while (!commit_seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (abort_after >= 0 && pops == abort_after) break;
      case (mode)
        0: word_ready = 1'b1;
        1: word_ready = cyc[0];
        default: word_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        check("stall_valid", word_valid, 1);
        check("stall_word", word_out, held);
      end
      stalled = 0;
      if (word_valid) begin
        if (word_ready) begin
          if (q.size() == 0) begin
            check("extra_word", word_out, 0);
          end else begin
            exp = q.pop_front();
            pops++;
            check("word", word_out, exp);
            if (exp[31]) begin
              commit_seen = 1;
              if (mode == 0) check("commit_cycle", cyc, NCH + 1);
            end
          end
        end else begin
          stalled = 1;
          held = word_out;
        end
      end
    end
    if (abort_after >= 0) begin
      rst_n = 1'b0;
      #1;
      check("rst_word_valid", word_valid, 0);
      check("rst_frame_ready", frame_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      model_shadow_ok = 0;
      model_shadow = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      word_ready = 1'b0;
    end else begin
      check("commit_seen", commit_seen, 1);
      check("words_left", q.size(), 0);
      model_shadow = f;
      model_shadow_ok = 1;
      @(negedge clk);
      check("done_pulse", done, 1);
      check("done_frame_ready", frame_ready, 1);
      check("done_busy", busy, 0);
    end
  endtask

  initial begin
    logic [DEPTH-1:0] fa, fb, cur;
`ifdef IMAGE_TX_DELTA_EN
    delta_en = 1;
`else
    delta_en = 0;
`endif
    fa = 64'h4444_3333_2222_1111;
    fb = 64'h4444_3333_AAAA_1111;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_frame_ready", frame_ready, 1);
    check("reset_word_valid", word_valid, 0);
    check("reset_word_out", word_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_frame_ready", frame_ready, 1);
    check("idle_word_valid", word_valid, 0);
    check("idle_busy", busy, 0);

    // Directed: full frame, then same frame with stalls
    run_frame(fa, 0, 0, 0, '0, -1);
    run_frame(fa, 1, 0, 0, '0, -1);

    // Reset after two words, then a fresh frame restarts at addr 0
    run_frame(fb, 0, 0, 0, '0, 2);
    run_frame(fa, 0, 0, 0, '0, -1);

    // Delta-style update of one chunk
    run_frame(fb, 0, 0, 0, '0, -1);

    // Back-to-back: second frame accepted in the done cycle
    run_frame(fa, 0, 0, 1, 64'h0123_4567_89AB_CDEF, -1);
    check("btb_valid_hold", frame_valid, 1);
    run_frame(64'h0123_4567_89AB_CDEF, 0, 1, 0, '0, -1);

    // Randomized frames with partially reused chunks
    cur = {$urandom, $urandom};
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 1) == 1) cur[16*i +: 16] = 16'($urandom);
      run_frame(cur, int'($urandom_range(0, 2)), 0, 0, '0, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
